// File: rtl/mem_arb_pkg.sv
// Shared types for the memory-port arbiter: FSM states, port owners and
// the byte-lane count of the memory interface.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_ACCESS = 2'd1,
    ARB_RESP   = 2'd2
  } arb_state_e;

  // The encoding doubles as the bit index of each requester in req/gnt vectors.
  typedef enum logic {
    OWNER_IF = 1'b0,
    OWNER_D  = 1'b1
  } arb_owner_e;

  localparam int BE_W = 4;

endpackage

// File: rtl/arb_pick2.sv
// Combinational two-way picker for the memory-port arbiter.
// req[0] = fetch, req[1] = data; gnt is one-hot, or zero when nothing is requested.
// Build option MEM_ARB_DATA_PRIO_EN: when defined, data always wins a tie.
// Otherwise a tie goes to the port that was not granted last.
module arb_pick2
  import mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  arb_owner_e last_owner,
  output logic [1:0] gnt
);

`ifdef MEM_ARB_DATA_PRIO_EN
  // last_owner is still tracked by the top level but plays no part in fixed priority.
  logic unused_last_owner;
  assign unused_last_owner = (last_owner == OWNER_D);
`endif

  // Resolve a single requester directly, and a tie by the configured policy.
  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01: gnt = 2'b01;
      2'b10: gnt = 2'b10;
`ifdef MEM_ARB_DATA_PRIO_EN
      2'b11: gnt = 2'b10;
`else
      2'b11: gnt = (last_owner == OWNER_D) ? 2'b01 : 2'b10;
`endif
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one synchronous-read memory port between instruction fetch and
// load/store. It runs one access at a time, and each access occupies the
// port for three cycles.
// Build option MEM_ARB_DATA_PRIO_EN (applied in arb_pick2): data wins every tie.
//
// state      | meaning
// -----------+------------------------------------------------------------
// ARB_IDLE   | port free; grant a pending request and capture its payload
// ARB_ACCESS | mem_en high, address/write data/byte enables presented
// ARB_RESP   | mem_rdata valid; pulse the owner's rvalid
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  input  logic [BE_W-1:0]   d_be,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic [BE_W-1:0]   mem_we,
  output logic [ADDR_W-3:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  arb_state_e state;
  arb_owner_e owner;
  arb_owner_e last_owner;
  logic       cap_store;
  logic [1:0] pick;

  // Byte addresses only carry the word address to memory; alignment is not checked.
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^{if_addr[1:0], d_addr[1:0]};

  arb_pick2 u_pick (
    .req        ({d_req, if_req}),
    .last_owner (last_owner),
    .gnt        (pick)
  );

  // Grants exist only while the port is free.
  assign if_gnt = (state == ARB_IDLE) && pick[OWNER_IF];
  assign d_gnt  = (state == ARB_IDLE) && pick[OWNER_D];

  // The response goes to the owner only; the other port sees zeros.
  assign if_rvalid = (state == ARB_RESP) && (owner == OWNER_IF);
  assign d_rvalid  = (state == ARB_RESP) && (owner == OWNER_D);
  assign if_rdata  = if_rvalid ? mem_rdata : '0;
  assign d_rdata   = (d_rvalid && !cap_store) ? mem_rdata : '0;

  // Sequencer: capture the winner into the registered memory-side outputs, then
  // strobe for one cycle and return the response one cycle later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ARB_IDLE;
      owner      <= OWNER_IF;
      last_owner <= OWNER_IF;
      cap_store  <= 1'b0;
      mem_en     <= 1'b0;
      mem_we     <= '0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (pick != 2'b00) begin
            state      <= ARB_ACCESS;
            owner      <= pick[OWNER_D] ? OWNER_D : OWNER_IF;
            last_owner <= pick[OWNER_D] ? OWNER_D : OWNER_IF;
            cap_store  <= pick[OWNER_D] && d_we;
            mem_en     <= 1'b1;
            mem_addr   <= pick[OWNER_D] ? d_addr[ADDR_W-1:2] : if_addr[ADDR_W-1:2];
            mem_we     <= (pick[OWNER_D] && d_we) ? d_be : '0;
            mem_wdata  <= pick[OWNER_D] ? d_wdata : '0;
          end
        end
        ARB_ACCESS: begin
          state  <= ARB_RESP;
          mem_en <= 1'b0;
          mem_we <= '0;
        end
        ARB_RESP: begin
          state <= ARB_IDLE;
        end
        default: begin
          state <= ARB_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: single fetch, store, tie ordering,
// request during an access, reset mid-access and an idle stretch.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_be;
  logic        d_gnt;
  logic        d_rvalid;
  logic [31:0] d_rdata;
  logic        mem_en;
  logic [3:0]  mem_we;
  logic [29:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_gnt    (if_gnt),
    .if_rvalid (if_rvalid),
    .if_rdata  (if_rdata),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_be      (d_be),
    .d_gnt     (d_gnt),
    .d_rvalid  (d_rvalid),
    .d_rdata   (d_rdata),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Advance to just after the next rising edge; inputs are driven from here.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    if_req    = 1'b0;
    if_addr   = '0;
    d_req     = 1'b0;
    d_we      = 1'b0;
    d_addr    = '0;
    d_wdata   = '0;
    d_be      = '0;
    mem_rdata = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 1'b0;
    cyc();
    cyc();
    rst_n = 1'b1;
    #1;
  endtask

  initial begin
    logic [1:0] exp_g;
    logic [1:0] g_hist [0:11];

    clear_inputs();
    rst_n = 1'b0;
    cyc();
    cyc();
    check_eq("rst_mem_en", mem_en, 0);
    check_eq("rst_mem_we", mem_we, 0);
    check_eq("rst_mem_addr", mem_addr, 0);
    check_eq("rst_mem_wdata", mem_wdata, 0);
    check_eq("rst_rvalid", {d_rvalid, if_rvalid}, 0);
    check_eq("rst_gnt", {d_gnt, if_gnt}, 0);
    rst_n = 1'b1;
    cyc();

    // Fetch only
    if_req = 1'b1; if_addr = 32'h0000_0010;
    #1 check_eq("fetch_gnt_c0", {d_gnt, if_gnt}, 2'b01);
    cyc();
    if_req = 1'b0;
    #1;
    check_eq("fetch_en_c1", mem_en, 1);
    check_eq("fetch_addr_c1", mem_addr, 30'h4);
    check_eq("fetch_we_c1", mem_we, 0);
    check_eq("fetch_gnt_c1", {d_gnt, if_gnt}, 0);
    cyc();
    mem_rdata = 32'h0000_0013;
    #1;
    check_eq("fetch_rvalid_c2", {d_rvalid, if_rvalid}, 2'b01);
    check_eq("fetch_rdata_c2", if_rdata, 32'h13);
    check_eq("fetch_d_rdata_c2", d_rdata, 0);
    check_eq("fetch_en_c2", mem_en, 0);
    cyc();
    mem_rdata = '0;

    // Store
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h100; d_be = 4'b0011; d_wdata = 32'hDEAD_BEEF;
    #1 check_eq("store_gnt_c0", {d_gnt, if_gnt}, 2'b10);
    cyc();
    d_req = 1'b0; d_we = 1'b0; d_wdata = '0; d_be = '0;
    #1;
    check_eq("store_en_c1", mem_en, 1);
    check_eq("store_we_c1", mem_we, 4'b0011);
    check_eq("store_addr_c1", mem_addr, 30'h40);
    check_eq("store_wdata_c1", mem_wdata, 32'hDEAD_BEEF);
    cyc();
    mem_rdata = 32'h1234_5678;
    #1;
    check_eq("store_rvalid_c2", {d_rvalid, if_rvalid}, 2'b10);
    check_eq("store_rdata_c2", d_rdata, 0);
    check_eq("store_if_rdata_c2", if_rdata, 0);
    check_eq("store_we_c2", mem_we, 0);
    cyc();
    check_eq("store_idle_c3", {d_rvalid, if_rvalid, mem_en}, 0);

    // Tie from reset: both held for four grants
    do_reset();
    cyc();
    if_req = 1'b1; if_addr = 32'h20;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h200;
    for (int c = 0; c < 12; c++) begin
      #1;
      if (c % 3 == 0) begin
`ifdef MEM_ARB_DATA_PRIO_EN
        exp_g = 2'b10;
`else
        exp_g = ((c / 3) % 2 == 0) ? 2'b10 : 2'b01;
`endif
      end else begin
        exp_g = 2'b00;
      end
      g_hist[c] = {d_gnt, if_gnt};
      check_eq($sformatf("tie_gnt_c%0d", c), {d_gnt, if_gnt}, exp_g);
      if (c % 3 == 2) begin
`ifdef MEM_ARB_DATA_PRIO_EN
        exp_g = 2'b10;
`else
        exp_g = (((c - 2) / 3) % 2 == 0) ? 2'b10 : 2'b01;
`endif
        check_eq($sformatf("tie_rvalid_c%0d", c), {d_rvalid, if_rvalid}, exp_g);
      end
      cyc();
    end
    clear_inputs();
    cyc();
    cyc();
    cyc();

    // Fetch arriving while a load is in ACCESS waits until the port is free
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h300;
    #1 check_eq("late_d_gnt_c0", {d_gnt, if_gnt}, 2'b10);
    cyc();
    d_req = 1'b0;
    if_req = 1'b1; if_addr = 32'h44;
    #1 check_eq("late_gnt_c1", {d_gnt, if_gnt}, 0);
    cyc();
    mem_rdata = 32'hCAFE_0001;
    #1;
    check_eq("late_gnt_c2", {d_gnt, if_gnt}, 0);
    check_eq("late_load_rdata_c2", d_rdata, 32'hCAFE_0001);
    check_eq("late_load_rvalid_c2", {d_rvalid, if_rvalid}, 2'b10);
    cyc();
    mem_rdata = '0;
    #1 check_eq("late_gnt_c3", {d_gnt, if_gnt}, 2'b01);
    cyc();
    if_req = 1'b0;
    #1 check_eq("late_addr_c4", mem_addr, 30'h11);
    cyc();
    #1 check_eq("late_rvalid_c5", {d_rvalid, if_rvalid}, 2'b01);
    cyc();

    // Reset asserted during ACCESS
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h400; d_be = 4'hF; d_wdata = 32'h5555_AAAA;
    #1 check_eq("rma_gnt_c0", {d_gnt, if_gnt}, 2'b10);
    cyc();
    clear_inputs();
    #1 check_eq("rma_en_c1", mem_en, 1);
    #1 rst_n = 1'b0;
    #1;
    check_eq("rma_en_async", mem_en, 0);
    check_eq("rma_we_async", mem_we, 0);
    cyc();
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1 check_eq($sformatf("rma_no_rvalid_%0d", c), {d_rvalid, if_rvalid, mem_en}, 0);
      cyc();
    end
    if_req = 1'b1; if_addr = 32'h80;
    #1 check_eq("rma_new_gnt", {d_gnt, if_gnt}, 2'b01);
    cyc();
    if_req = 1'b0;
    #1 check_eq("rma_new_addr", mem_addr, 30'h20);
    cyc();
    #1 check_eq("rma_new_rvalid", {d_rvalid, if_rvalid}, 2'b01);
    cyc();

    // Idle stretch
    for (int c = 0; c < 10; c++) begin
      #1 check_eq($sformatf("idle_%0d", c), {mem_en, d_gnt, if_gnt, d_rvalid, if_rvalid}, 0);
      cyc();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester arbiter and sequencer for the single-port, synchronous-read instruction/data memory of the RISC-V core. It shares one memory port between the instruction-fetch path (read-only) and the load/store path (read/write with byte enables). It handles one access at a time with a fixed 3-cycle occupancy. It sits between the CPU control FSM and the memory macro, and replaces the direct `instruction` input as the core's only path to memory.

## Interface
- `ADDR_W`, default 32: byte-address width of both requesters.
- `DATA_W`, default 32: data width; fixed at 32 (4 byte lanes).
- `clk` input 1: single clock; all state updates on posedge.
- `rst_n` input 1: asynchronous, active-low reset.
- `if_req` input 1: fetch request; held with `if_addr` until `if_gnt`.
- `if_addr` input ADDR_W: fetch byte address.
- `if_gnt` output 1: fetch request accepted this cycle.
- `if_rvalid` output 1: fetch read data valid (1-cycle pulse).
- `if_rdata` output DATA_W: fetch read data.
- `d_req` input 1: data request; held with its payload until `d_gnt`.
- `d_we` input 1: 1 = store, 0 = load.
- `d_addr` input ADDR_W: data byte address.
- `d_wdata` input DATA_W: store data.
- `d_be` input 4: store byte enables.
- `d_gnt` output 1: data request accepted this cycle.
- `d_rvalid` output 1: load data valid, or store-complete ack (1-cycle pulse).
- `d_rdata` output DATA_W: load data; 0 on store ack.
- `mem_en` output 1: memory access strobe.
- `mem_we` output 4: per-byte write enables.
- `mem_addr` output ADDR_W-2: word address.
- `mem_wdata` output DATA_W: write data.
- `mem_rdata` input DATA_W: memory read data, valid the cycle after `mem_en`.

## Operation
- FSM states: `ARB_IDLE`, `ARB_ACCESS`, `ARB_RESP`.
- **ARB_IDLE:**
  - If any request is pending, pick a winner and assert its gnt (combinational, this cycle only).
  - On the edge: capture the owner plus addr/we/be/wdata (fetch forces we=0), then go to `ARB_ACCESS`.
  - No request: stay in `ARB_IDLE`.
- **ARB_ACCESS:**
  - Drive `mem_en`=1, `mem_addr`=captured addr[ADDR_W-1:2], `mem_wdata`=captured wdata.
  - Drive `mem_we`=captured we ? be : 4'b0.
  - Then go to `ARB_RESP`.
- **ARB_RESP:**
  - Pulse the owner's rvalid.
  - Owner rdata = `mem_rdata` for a read; 0 for a store ack.
  - Then go to `ARB_IDLE`.
- Arbitration: if only one port requests, it wins.
- Tie: round-robin. The port not granted last wins.
- `last_owner` resets to fetch, so the first tie goes to data.
- gnt is never asserted outside `ARB_IDLE`. Requests arriving in ACCESS/RESP wait.
- Address bits [1:0] are ignored. No misalignment check.
- The non-owner's rvalid stays 0. Its rdata is driven 0.
- Reset (async, any state):
  - state→`ARB_IDLE`, `last_owner`→fetch.
  - All outputs 0; captured regs cleared.
  - An in-flight access is abandoned, with no rvalid for it after reset release.
  - A write whose ACCESS cycle completed before reset is not rolled back.

## Timing
- Cycle 0: req high in IDLE → gnt=1.
- Cycle 1: mem_en=1.
- Cycle 2: rvalid=1.
- Next grant is possible in cycle 3.
- Latency req→rvalid is 2 cycles when uncontended.
- Throughput is 1 access per 3 cycles.
- `mem_en`, `mem_we`, `mem_addr`, `mem_wdata` are registered outputs.
- `if_gnt`/`d_gnt` are combinational from state, requests and `last_owner`.
- `*_rvalid` decode from registered state/owner; `*_rdata` passes `mem_rdata` through combinationally.
- Reset value of every output: 0.

## Configuration
- `MEM_ARB_DATA_PRIO_EN` defined: fixed priority; data always wins ties. `last_owner` still updates but does not affect arbitration.
- `MEM_ARB_DATA_PRIO_EN` undefined: round-robin as above.

## Structure
- Package `mem_arb_pkg`:
  - `arb_state_e` {ARB_IDLE, ARB_ACCESS, ARB_RESP}.
  - `arb_owner_e` {OWNER_IF, OWNER_D}.
  - `BE_W`=4.
- Sub-module `arb_pick2`: combinational 2-way picker.
  - Inputs: req[1:0], last_owner.
  - Output: one-hot grant.
  - Macro-dependent priority is contained here.
- The top-level holds the FSM, capture registers and response steering.

## Test plan
- Fetch only: if_req, if_addr=0x0000_0010, mem_rdata=0x0000_0013 in cycle 2 → if_gnt@0, mem_en=1/mem_addr=0x4/mem_we=0@1, if_rvalid=1/if_rdata=0x13@2, d_rvalid=0.
- Store: d_we=1, d_addr=0x100, d_be=4'b0011, d_wdata=0xDEAD_BEEF → mem_we=4'b0011, mem_addr=0x40, mem_wdata=0xDEADBEEF@1; d_rvalid=1, d_rdata=0@2.
- Tie after reset, both req held: grant order D, IF, D, IF at cycles 0, 3, 6, 9. With `MEM_ARB_DATA_PRIO_EN`: D every grant, IF starved while d_req held.
- Request arriving in ACCESS: if_req rises at cycle 1 of a data access → no if_gnt in cycles 1–2; if_gnt at cycle 3.
- Reset mid-access: assert rst_n=0 asynchronously during ACCESS → mem_en drops immediately; after release, no rvalid; a new req is granted from IDLE.
- Idle: no requests for 10 cycles → mem_en=0, both gnt/rvalid=0 throughout.
